// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit: FSM encoding and default widths.
package mem_access_unit_pkg;

  localparam int unsigned MAU_DATA_W     = 16;
  localparam int unsigned MAU_ADDR_W     = 16;
  localparam int unsigned MAU_MAX_WAIT   = 15;
  localparam int unsigned MAU_WAIT_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mau_state_e;

endpackage

// File: rtl/mau_wait_counter.sv
// Counts ACCESS cycles; tc_o flags the MAX_WAIT-th cycle of the current access.
module mau_wait_counter
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MAU_MAX_WAIT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en_i,
  input  logic clr_i,
  output logic tc_o
);

  localparam logic [MAU_WAIT_CNT_W-1:0] LAST = MAU_WAIT_CNT_W'(MAX_WAIT - 1);

  logic [MAU_WAIT_CNT_W-1:0] count_q, count_d;

  assign tc_o = en_i && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && !tc_o) begin
      count_d = count_q + MAU_WAIT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Sequences one core request into a single strobed memory access (IDLE -> ACCESS -> DONE).
// Optional access timeout is built when MEM_ACCESS_UNIT_TIMEOUT_EN is defined.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned DATA_W   = MAU_DATA_W,
  parameter int unsigned ADDR_W   = MAU_ADDR_W,
  parameter int unsigned MAX_WAIT = MAU_MAX_WAIT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_fetch,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              cpu_err,
  output logic              busy,
  output logic              read_m,
  output logic              write_m,
  output logic [ADDR_W-1:0] address,
  inout  wire  [DATA_W-1:0] data,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] num_fetch,
  output mau_state_e        dbg_state_o
);

  // Handshake: a request is taken only when cpu_req is high in IDLE; mem_ack is
  // honoured only in ACCESS; cpu_ready (and cpu_err) pulse for the single DONE cycle.

  mau_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] nf_q, nf_d;
  logic              we_q, we_d;
  logic              fetch_q, fetch_d;
  logic              timeout;
  logic              err_flag;

`ifdef MEM_ACCESS_UNIT_TIMEOUT_EN
  logic wait_en;
  logic wait_clr;
  logic wait_tc;
  logic err_q, err_d;

  assign wait_en  = (state_q == ACCESS);
  assign wait_clr = (state_q != ACCESS);

  mau_wait_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (wait_en),
    .clr_i   (wait_clr),
    .tc_o    (wait_tc)
  );

  // An ack arriving on the terminal cycle still counts as success.
  always_comb begin
    err_d = err_q;
    if (state_q == ACCESS) begin
      err_d = wait_tc && !mem_ack;
    end
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign timeout  = wait_tc;
  assign err_flag = err_q;
`else
  logic unused_cfg;
  assign unused_cfg = (MAX_WAIT > 0);
  assign timeout    = 1'b0;
  assign err_flag   = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cpu_req) state_d = ACCESS;
      ACCESS:  if (mem_ack || timeout) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    read_m    = 1'b0;
    write_m   = 1'b0;
    busy      = 1'b0;
    cpu_ready = 1'b0;
    unique case (state_q)
      ACCESS: begin
        read_m  = !we_q;
        write_m = we_q;
        busy    = 1'b1;
      end
      DONE: begin
        busy      = 1'b1;
        cpu_ready = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    fetch_d = fetch_q;
    rdata_d = rdata_q;
    nf_d    = nf_q;
    if (state_q == IDLE && cpu_req) begin
      addr_d  = cpu_addr;
      wdata_d = cpu_wdata;
      we_d    = cpu_we;
      fetch_d = cpu_fetch;
    end
    if (state_q == ACCESS && mem_ack && !we_q) begin
      rdata_d = data;
    end
    // A fetch flagged together with a write is a plain write.
    if (state_q == DONE && fetch_q && !we_q && !err_flag) begin
      nf_d = nf_q + DATA_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      fetch_q <= 1'b0;
      rdata_q <= '0;
      nf_q    <= '0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      fetch_q <= fetch_d;
      rdata_q <= rdata_d;
      nf_q    <= nf_d;
    end
  end

  assign address     = (state_q == ACCESS) ? addr_q : '0;
  assign data        = write_m ? wdata_q : {DATA_W{1'bz}};
  assign cpu_err     = (state_q == DONE) && err_flag;
  assign cpu_rdata   = rdata_q;
  assign num_fetch   = nf_q;
  assign dbg_state_o = state_q;

endmodule
